// File: rtl/glyph_scan_ctrl.sv
// glyph_scan_ctrl: scans the 16 rows of one glyph out of the glyph BRAM at a
// fixed dwell per row, and shares the BRAM ports with a host write channel.
//
// Ports:
//   clk, rst_n             clock, async active-low reset
//   en, glyph_sel          scan enable / glyph select (sampled at frame start)
//   wr_req/addr/data/ack   host write channel, ack is a same-cycle grant
//   bram_wr_en/waddr/din   BRAM write port
//   bram_raddr, bram_dout  BRAM read port (registered read, 1-cycle latency)
//   row_data, row_idx      current displayed row and its index
//   row_valid, frame_start one-cycle pulses on row update / row 0
//   busy                   scanner is not idle
module glyph_scan_ctrl #(
    parameter int DWELL  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [3:0]        glyph_sel,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              bram_wr_en,
    output logic [ADDR_W-1:0] bram_waddr,
    output logic [ADDR_W-1:0] bram_raddr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout,
    output logic [DATA_W-1:0] row_data,
    output logic [3:0]        row_idx,
    output logic              row_valid,
    output logic              frame_start,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        CAPTURE,
        HOLD
    } state_t;

    localparam logic [15:0] DWELL_LAST = 16'(DWELL - 1);

    state_t      state;
    logic [3:0]  cur_glyph;
    logic [3:0]  row_cnt;
    logic [3:0]  row_nxt;
    logic [15:0] dwell_cnt;
    logic        row_end;
    logic        grant;

    assign row_nxt = row_cnt + 4'd1;
    assign row_end = (dwell_cnt == DWELL_LAST);

    // The scan read owns the BRAM in FETCH; a write is granted in any
    // other cycle. Gating with rst_n drops a pending write during reset.
    assign grant      = rst_n && wr_req && (state != FETCH);
    assign wr_ack     = grant;
    assign bram_wr_en = grant;
    assign bram_waddr = wr_addr;
    assign bram_din   = wr_data;
    assign busy       = (state != IDLE);

    // bram_raddr is loaded on the edge entering FETCH so that the BRAM
    // samples it at the end of FETCH and returns data during CAPTURE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cur_glyph   <= 4'd0;
            row_cnt     <= 4'd0;
            dwell_cnt   <= 16'd0;
            bram_raddr  <= '0;
            row_data    <= '0;
            row_idx     <= 4'd0;
            row_valid   <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            row_valid   <= 1'b0;
            frame_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (en) begin
                        cur_glyph  <= glyph_sel;
                        row_cnt    <= 4'd0;
                        dwell_cnt  <= 16'd0;
                        bram_raddr <= ADDR_W'({glyph_sel, 4'h0});
                        state      <= FETCH;
                    end
                end
                FETCH: begin
                    dwell_cnt <= dwell_cnt + 16'd1;
                    state     <= CAPTURE;
                end
                CAPTURE: begin
                    dwell_cnt   <= dwell_cnt + 16'd1;
                    row_data    <= bram_dout;
                    row_idx     <= row_cnt;
                    row_valid   <= 1'b1;
                    frame_start <= (row_cnt == 4'd0);
                    state       <= HOLD;
                end
                HOLD: begin
                    if (row_end) begin
                        dwell_cnt <= 16'd0;
                        if (row_cnt != 4'hF) begin
                            row_cnt    <= row_nxt;
                            bram_raddr <= ADDR_W'({cur_glyph, row_nxt});
                            state      <= FETCH;
                        end else if (en) begin
                            cur_glyph  <= glyph_sel;
                            row_cnt    <= 4'd0;
                            bram_raddr <= ADDR_W'({glyph_sel, 4'h0});
                            state      <= FETCH;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_glyph_scan_ctrl.sv
// tb_glyph_scan_ctrl: scoreboard bench for glyph_scan_ctrl with a BRAM model,
// a frame-position reference model and a randomized host write agent.
module tb_glyph_scan_ctrl;

    localparam int D  = 5;
    localparam int FR = 16 * D;

    typedef struct {
        int          cyc;
        logic [3:0]  row;
        logic [15:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [3:0]  glyph_sel;
    logic        wr_req;
    logic [7:0]  wr_addr;
    logic [15:0] wr_data;
    logic        wr_ack;
    logic        bram_wr_en;
    logic [7:0]  bram_waddr;
    logic [7:0]  bram_raddr;
    logic [15:0] bram_din;
    logic [15:0] bram_dout;
    logic [15:0] row_data;
    logic [3:0]  row_idx;
    logic        row_valid;
    logic        frame_start;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    exp_t        q[$];
    logic [15:0] shadow [256];
    logic [15:0] mem [256];
    logic        load;

    int          m_p = -1;
    logic [3:0]  m_glyph = 4'd0;
    logic [7:0]  m_ra = 8'd0;
    int          pend = 0;
    bit          ack_seen = 0;
    bit          g_rand = 0;
    logic [15:0] last_data = 16'd0;
    int          rv_count = 0;

    int          h_seq = 0;
    int          h_done = 0;
    int          h_kind = 0;
    int          h_count = 0;
    logic [7:0]  h_addr = 8'd0;
    logic [15:0] h_data = 16'd0;
    int          h_left = 0;
    int          h_k = 0;

    glyph_scan_ctrl #(.DWELL(D), .ADDR_W(8), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .glyph_sel(glyph_sel),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(wr_ack), .bram_wr_en(bram_wr_en),
        .bram_waddr(bram_waddr), .bram_raddr(bram_raddr),
        .bram_din(bram_din), .bram_dout(bram_dout),
        .row_data(row_data), .row_idx(row_idx), .row_valid(row_valid),
        .frame_start(frame_start), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] pat(logic [7:0] a);
        return {a[7:4], 4'h0, a[3:0], 4'hA};
    endfunction

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < 256; i++) mem[i] <= pat(8'(i));
        end else if (bram_wr_en) begin
            mem[bram_waddr] <= bram_din;
        end
        bram_dout <= mem[bram_raddr];
    end

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic chk_reset();
        chk("rst_row_data", row_data, 0);
        chk("rst_row_idx", row_idx, 0);
        chk("rst_row_valid", row_valid, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_raddr", bram_raddr, 0);
        chk("rst_wr_en", bram_wr_en, 0);
        chk("rst_wr_ack", wr_ack, 0);
    endtask

    // Reference: the scanner is a position within a frame of 16*D cycles,
    // each row starting with its fetch cycle at a multiple of D.
    task automatic step_model();
        logic [3:0] row;
        logic [7:0] a;
        bit         fetch;
        bit         grant;
        if (!rst_n) begin
            m_p = -1;
            m_ra = 8'd0;
            q.delete();
            pend = 0;
            ack_seen = 0;
            chk_reset();
            return;
        end
        if (m_p < 0) begin
            if (en) begin m_p = 0; m_glyph = glyph_sel; end
        end else if (m_p % D != D - 1) begin
            m_p++;
        end else if (m_p != FR - 1) begin
            m_p++;
        end else if (en) begin
            m_p = 0;
            m_glyph = glyph_sel;
        end else begin
            m_p = -1;
        end
        fetch = (m_p >= 0) && (m_p % D == 0);
        chk("busy", busy, m_p >= 0);
        if (fetch) begin
            row = 4'(m_p / D);
            a = {m_glyph, row};
            m_ra = a;
            chk("raddr_fetch", bram_raddr, a);
            q.push_back('{cyc + 2, row, shadow[a]});
        end else begin
            chk("raddr_hold", bram_raddr, m_ra);
        end
        grant = wr_req && !fetch;
        chk("wr_ack", wr_ack, grant);
        chk("bram_wr_en", bram_wr_en, grant);
        if (grant) begin
            chk("bram_waddr", bram_waddr, wr_addr);
            chk("bram_din", bram_din, wr_data);
            shadow[wr_addr] = wr_data;
        end
        if (wr_req && !wr_ack) pend++;
        else pend = 0;
        if (wr_req) chk("ack_within_1", pend <= 1, 1);
        ack_seen = wr_ack;
    endtask

    function automatic bit next_is_fetch();
        if (m_p < 0) return en;
        if (m_p % D != D - 1) return 0;
        if (m_p != FR - 1) return 1;
        return en;
    endfunction

    // Host agent: drives the write channel just after each rising edge.
    initial begin : host
        wr_req = 0;
        wr_addr = 0;
        wr_data = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                wr_req = 0;
                h_left = 0;
                h_done = h_seq;
            end else begin
                if (wr_req && ack_seen) begin
                    wr_req = 0;
                    h_left--;
                    if (h_left == 0) h_done = h_seq;
                end
                if (h_left == 0 && !wr_req && h_done != h_seq) begin
                    h_left = h_count;
                    h_k = h_kind;
                end
                if (h_left > 0 && !wr_req) begin
                    if (h_k == 0 || (h_k == 1 && next_is_fetch()) ||
                        (h_k == 2 && $urandom_range(2, 0) != 0)) begin
                        wr_req = 1;
                        wr_addr = (h_k == 2) ? 8'($urandom) : h_addr;
                        wr_data = (h_k == 2) ? 16'($urandom) : h_data;
                    end
                end
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                last_data = 16'd0;
            end else if (row_valid) begin
                rv_count++;
                if (q.size() == 0) begin
                    chk("unexpected_row_valid", q.size(), 1);
                end else begin
                    e = q.pop_front();
                    chk("row_valid_cycle", cyc, e.cyc);
                    chk("row_data", row_data, e.data);
                    chk("row_idx", row_idx, e.row);
                    chk("frame_start", frame_start, e.row == 4'd0);
                    last_data = e.data;
                end
            end else begin
                chk("frame_start_idle", frame_start, 0);
                chk("row_data_hold", row_data, last_data);
                if (q.size() != 0 && q[0].cyc <= cyc) begin
                    chk("row_valid_missing", row_valid, 1);
                    e = q.pop_front();
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        step_model();
        if (g_rand && $urandom_range(3, 0) == 0) glyph_sel = 4'($urandom);
    endtask

    task automatic wait_p(int p, int lim);
        int n = 0;
        while (m_p != p && n < lim) begin
            tick();
            n++;
        end
        chk("reach_phase", m_p, p);
    endtask

    task automatic host_cmd(int kind, int count, logic [7:0] a,
                            logic [15:0] d, int lim);
        int n = 0;
        h_kind = kind;
        h_count = count;
        h_addr = a;
        h_data = d;
        h_seq++;
        while (h_done != h_seq && n < lim) begin
            tick();
            n++;
        end
        chk("host_cmd_done", h_done, h_seq);
    endtask

    initial begin : main
        logic [15:0] old;
        int          rv_mark;
        rst_n = 0;
        en = 0;
        glyph_sel = 4'd0;
        load = 1;
        for (int i = 0; i < 256; i++) shadow[i] = pat(8'(i));
        repeat (3) tick();
        load = 0;
        rst_n = 1;

        // Glyph 3 frame; select change mid-frame only lands next frame.
        en = 1;
        glyph_sel = 4'd3;
        wait_p(7 * D + 2, 2 * FR);
        glyph_sel = 4'd5;
        wait_p(2, 2 * FR);
        chk("frame2_raddr_row0", bram_raddr, 8'h50);

        // Write request raised during FETCH, then random writes.
        host_cmd(1, 1, 8'h21, 16'hC0DE, 4 * FR);
        g_rand = 1;
        host_cmd(2, 100, 8'h00, 16'h0000, 40 * FR);
        g_rand = 0;

        // Write to the displayed row of glyph 1.
        glyph_sel = 4'd1;
        wait_p(FR - 1, 2 * FR);
        wait_p(2 * D + 2, 2 * FR);
        old = shadow[8'h12];
        chk("row2_before_write", row_data, old);
        host_cmd(0, 1, 8'h12, 16'hBEEF, 4 * D);
        chk("row2_kept_after_write", row_data, old);
        wait_p(FR - 1, 2 * FR);
        wait_p(2 * D + 2, 2 * FR);
        chk("row2_next_frame", row_data, 16'hBEEF);

        // Drop enable at row 4: rows 5..15 still shown, then idle.
        wait_p(4 * D + 3, 2 * FR);
        rv_mark = rv_count;
        en = 0;
        wait_p(-1, 2 * FR);
        chk("busy_after_drop", busy, 0);
        repeat (3 * D) tick();
        chk("rows_after_drop", rv_count - rv_mark, 11);

        // Reset at row 9 with a write pending from the fetch cycle.
        en = 1;
        glyph_sel = 4'd7;
        wait_p(8 * D + 2, 2 * FR);
        h_kind = 1;
        h_count = 1;
        h_addr = 8'h44;
        h_data = 16'h1234;
        h_seq++;
        wait_p(9 * D, 2 * FR);
        rst_n = 0;
        #1;
        chk_reset();
        tick();
        tick();
        chk("wr_req_dropped", wr_req, 0);
        rst_n = 1;
        wait_p(2, 4 * D);
        chk("restart_row_idx", row_idx, 0);
        chk("restart_frame_start", frame_start, 1);
        chk("restart_raddr", bram_raddr, 8'h70);

        en = 0;
        wait_p(-1, 2 * FR);
        repeat (2 * D) tick();
        chk("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/glyph_scan_ctrl.md
# glyph_scan_ctrl

Sequencing and arbitration controller for the 256x16 glyph BRAM (16 glyphs x 16 rows of 16 pixels) that feeds the character display. It scans the rows of one selected glyph at a fixed dwell per row and presents each row to the display output stage. It also shares the BRAM ports with a host write channel used to load font data. It replaces free-running address counters in front of the BRAM with a frame-aware state machine.

## Interface
- `DWELL`, default 256: cycles per displayed row, including fetch; legal range 4..65535.
- `ADDR_W`, default 8: BRAM address width; glyph index is `addr[7:4]`, row index is `addr[3:0]`.
- `DATA_W`, default 16: BRAM/row data width.
- `clk`, input, 1: clock, all logic on rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: scan enable, sampled only at frame boundaries.
- `glyph_sel`, input, 4: glyph to display, latched at each frame start.
- `wr_req`, input, 1: host write request; held with address/data until `wr_ack`.
- `wr_addr`, input, ADDR_W: host write address.
- `wr_data`, input, DATA_W: host write data.
- `wr_ack`, output, 1: one-cycle pulse, write performed this cycle.
- `bram_wr_en`, output, 1: BRAM write enable.
- `bram_waddr`, output, ADDR_W: BRAM write address.
- `bram_raddr`, output, ADDR_W: BRAM read address.
- `bram_din`, output, DATA_W: BRAM write data.
- `bram_dout`, input, DATA_W: BRAM registered read data, valid 1 cycle after `bram_raddr`.
- `row_data`, output, DATA_W: current row pixels, held for the row period.
- `row_idx`, output, 4: index of the row in `row_data`.
- `row_valid`, output, 1: one-cycle pulse when `row_data` updates.
- `frame_start`, output, 1: one-cycle pulse coincident with the row 0 `row_valid`.
- `busy`, output, 1: high whenever the state is not IDLE.

## Operation
- States:
  - IDLE → FETCH when `en`=1; `glyph_sel` is latched into `cur_glyph` and `row_cnt` is set to 0.
  - FETCH: 1 cycle; `bram_raddr` = {`cur_glyph`, `row_cnt`}; → CAPTURE.
  - CAPTURE: 1 cycle; `row_data` <= `bram_dout`, `row_idx` <= `row_cnt`, `row_valid` pulses (and `frame_start` if `row_cnt`=0); → HOLD.
  - HOLD: waits until `dwell_cnt` = DWELL-1, then:
    - If `row_cnt` < 15: `row_cnt`++ → FETCH.
    - If `row_cnt` = 15 (frame end) and `en`=1: relatch `glyph_sel`, `row_cnt` = 0 → FETCH.
    - If `row_cnt` = 15 and `en`=0: → IDLE.
- `dwell_cnt` is 16-bit. It clears on entry to FETCH and increments every cycle in FETCH, CAPTURE and HOLD, so the row period is exactly DWELL cycles.
- `bram_raddr` holds its last value outside FETCH. No read address change occurs during CAPTURE.
- `en` deassertion mid-frame has no effect until the frame end; the frame always completes all 16 rows.
- `glyph_sel` changes mid-frame are ignored until the next frame start.
- Write arbitration (scan read has priority):
  - A write is granted in any cycle where `wr_req`=1 and state ≠ FETCH.
  - On grant: `bram_wr_en`=1, `bram_waddr`=`wr_addr`, `bram_din`=`wr_data`, and `wr_ack`=1, all combinational in the same cycle.
  - A request arriving in FETCH is acked the next cycle.
- A write to the row currently being fetched is serialized after the read. The displayed `row_data` keeps the old value until the next frame.
- `bram_wr_en` is never 1 in FETCH.
- After an ack, the host must drop `wr_req` or present a new address/data. Back-to-back writes are acked every non-FETCH cycle.

## Timing
- Reset values:
  - State IDLE; `row_data`=0, `row_idx`=0, `row_valid`=0, `frame_start`=0, `busy`=0.
  - `bram_raddr`=0, `bram_wr_en`=0, `wr_ack`=0.
  - `cur_glyph`=0, `row_cnt`=0, `dwell_cnt`=0.
- Reset asserted mid-frame returns to IDLE immediately. Pending writes are dropped with no ack.
- Latency:
  - `en` rising in IDLE → FETCH next cycle → `row_valid` 2 cycles after `en` is sampled.
  - `row_valid` pulses are exactly DWELL cycles apart within and across frames; frame period = 16·DWELL.
- `wr_ack` latency: 0 cycles normally, 1 cycle if `wr_req` rises during FETCH; worst case 1 cycle.

## Test plan
- Reset, then `en`=1, `glyph_sel`=3, BRAM preloaded with row r of glyph g = {g,4'h0,r,4'hA} → `bram_raddr` steps 0x30..0x3F, each `row_data` matches, `frame_start` on row 0 only, `row_valid` spacing = 256.
- DWELL=4, continuous `en`, `glyph_sel` changed 2→5 at row 7 → remainder of frame shows glyph 2; next frame reads 0x50.
- `wr_req` asserted with address 0x21 in a FETCH cycle → `wr_ack` next cycle, `bram_wr_en` never coincides with FETCH; 100 random writes all acked within ≤1 cycle.
- `en` dropped at row 4 → rows 5..15 still displayed, then `busy`=0 after the row 15 dwell, no further `row_valid`.
- Write to 0x12 while row 2 of glyph 1 is displayed → current `row_data` unchanged; next frame row 2 shows new data.
- `rst_n` pulsed low at row 9 with `wr_req` pending → all outputs at reset values asynchronously, no `wr_ack`; restart begins at row 0.
